// File: rtl/lfsr_encrypt_engine.sv
`timescale 1ns/1ps
// LFSR stream-cipher encryptor: space pre-pad, XOR keystream, write ciphertext.
// Define LFSR_ENC_PARITY_EN to place even parity of c[6:0] in c[7].
module lfsr_encrypt_engine #(
    parameter int NUM_BYTES = 64,
    parameter int MSG_MAX   = 54,
    parameter int CT_BASE   = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [4:0]        PreLength,
    input  logic [6:0]        TapPtrn,
    input  logic [6:0]        LfsrInit,
    output logic [ADDR_W-1:0] MemRdAddr,
    input  logic [7:0]        MemRdData,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemWrAddr,
    output logic [7:0]        MemWrData,
    output logic              Busy,
    output logic              Ack
);
    localparam int IW = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [4:0]      pre_q, pre_d;
    logic [6:0]      tap_q, tap_d;
    logic [6:0]      lfsr_q, lfsr_d;
    logic            armed_q, armed_d;

    logic [4:0]        pre_clamp;
    logic [6:0]        init_fix;
    logic [ADDR_W-1:0] i_ext, pre_ext, k;
    logic              in_msg, last;
    logic [6:0]        plain, ct_lo;
    logic [7:0]        ct;
    logic              unused_msb;

    assign pre_clamp = (PreLength < 5'd10) ? 5'd10 :
                       (PreLength > 5'd26) ? 5'd26 : PreLength;
    assign init_fix  = (LfsrInit == 7'd0) ? 7'd1 : LfsrInit;

    assign i_ext   = ADDR_W'(i_q);
    assign pre_ext = ADDR_W'(pre_q);
    assign k       = i_ext - pre_ext;
    assign in_msg  = (i_ext >= pre_ext) && (k < ADDR_W'(MSG_MAX));
    assign last    = (i_q == IW'(NUM_BYTES - 1));

    // Plaintext bit 7 is dropped; only seven bits are enciphered.
    assign unused_msb = MemRdData[7];
    assign plain      = in_msg ? MemRdData[6:0] : 7'h20;
    assign ct_lo      = plain ^ lfsr_q;
`ifdef LFSR_ENC_PARITY_EN
    assign ct = {^ct_lo, ct_lo};
`else
    assign ct = {1'b0, ct_lo};
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            pre_q   <= 5'd10;
            tap_q   <= '0;
            lfsr_q  <= 7'h01;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            pre_q   <= pre_d;
            tap_q   <= tap_d;
            lfsr_q  <= lfsr_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        pre_d   = pre_q;
        tap_d   = tap_q;
        lfsr_d  = lfsr_q;
        armed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                i_d     = '0;
                armed_d = Start;
                if (Start) begin
                    pre_d  = pre_clamp;
                    tap_d  = TapPtrn;
                    lfsr_d = init_fix;
                end else if (armed_q) begin
                    state_d = RD;
                end
            end
            RD: state_d = WR;
            WR: begin
                lfsr_d  = {lfsr_q[5:0], ^(lfsr_q & tap_q)};
                i_d     = last ? i_q : i_q + IW'(1);
                state_d = last ? DONE : RD;
            end
            DONE: begin
                if (Start) begin
                    state_d = IDLE;
                    armed_d = 1'b1;
                    pre_d   = pre_clamp;
                    tap_d   = TapPtrn;
                    lfsr_d  = init_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MemRdAddr = '0;
        MemWrEn   = 1'b0;
        MemWrAddr = '0;
        MemWrData = '0;
        Busy      = 1'b0;
        Ack       = 1'b0;
        unique case (state_q)
            RD: begin
                Busy = 1'b1;
                if (in_msg) MemRdAddr = k;
            end
            WR: begin
                Busy      = 1'b1;
                MemWrEn   = 1'b1;
                MemWrAddr = ADDR_W'(CT_BASE) + i_ext;
                MemWrData = ct;
            end
            DONE:    Ack = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
`timescale 1ns/1ps
// Directed bench for lfsr_encrypt_engine with a simple data-memory model.
module tb_lfsr_encrypt_engine;
    logic       Clk = 1'b0;
    logic       Reset, Start;
    logic [4:0] PreLength;
    logic [6:0] TapPtrn, LfsrInit;
    logic [7:0] MemRdAddr, MemWrAddr, MemWrData, MemRdData;
    logic       MemWrEn, Busy, Ack;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] exp_ct [64];
    logic [7:0] case1_ct [64];
    logic [7:0] hand1 [7];
    logic [7:0] rd_q;
    logic       ct_clr = 1'b0;
    int         wr_cnt = 0;
    int         checks = 0;
    int         failures = 0;

`ifdef LFSR_ENC_PARITY_EN
    localparam logic [7:0] B6  = 8'hE1;
    localparam logic [7:0] B90 = 8'hA5;
`else
    localparam logic [7:0] B6  = 8'h61;
    localparam logic [7:0] B90 = 8'h25;
`endif

    always #5 Clk = ~Clk;

    assign MemRdData = rd_q;

    always @(posedge Clk) begin
        rd_q <= pt_mem[MemRdAddr];
        if (ct_clr) begin
            for (int j = 0; j < 256; j++) ct_mem[j] <= 8'h80;
        end else if (MemWrEn) begin
            ct_mem[MemWrAddr] <= MemWrData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    lfsr_encrypt_engine dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .PreLength(PreLength), .TapPtrn(TapPtrn), .LfsrInit(LfsrInit),
        .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
        .MemWrEn(MemWrEn), .MemWrAddr(MemWrAddr), .MemWrData(MemWrData),
        .Busy(Busy), .Ack(Ack)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ct();
        ct_clr = 1'b1;
        tick();
        ct_clr = 1'b0;
    endtask

    task automatic launch(input logic [4:0] pl, input logic [6:0] tp,
                          input logic [6:0] li, input int stop_at,
                          input bit toggle, output int edges);
        PreLength = pl;
        TapPtrn   = tp;
        LfsrInit  = li;
        Start     = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        edges = 0;
        while (!Ack && edges < stop_at) begin
            tick();
            edges++;
            if (toggle)
                Start = (edges >= 20 && edges < 40) ? edges[0] : 1'b0;
        end
    endtask

    task automatic build_exp(input int pre, input logic [6:0] tap,
                             input logic [6:0] init);
        logic [6:0] lf, c;
        logic [7:0] p;
        int k;
        lf = (init == 7'd0) ? 7'd1 : init;
        for (int i = 0; i < 64; i++) begin
            k = i - pre;
            p = (k >= 0 && k < 54) ? pt_mem[k] : 8'h20;
            c = p[6:0] ^ lf;
`ifdef LFSR_ENC_PARITY_EN
            exp_ct[i] = {^c, c};
`else
            exp_ct[i] = {1'b0, c};
`endif
            lf = {lf[5:0], ^(lf & tap)};
        end
    endtask

    task automatic cmp_exp(input string tag, input int wc0);
        int mism = 0;
        for (int i = 0; i < 64; i++)
            if (ct_mem[64+i] !== exp_ct[i]) mism++;
        chk({tag, "_bytes"}, mism, 0);
        chk({tag, "_writes"}, wr_cnt - wc0, 64);
    endtask

    task automatic cmp_case1(input string tag, input int wc0);
        int mism = 0;
        for (int i = 0; i < 64; i++)
            if (ct_mem[64+i] !== case1_ct[i]) mism++;
        chk({tag, "_vs_case1"}, mism, 0);
        chk({tag, "_writes"}, wr_cnt - wc0, 64);
    endtask

    initial begin
        int edges, wc0, wen_seen, bad;
        hand1 = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, B6};
        for (int j = 0; j < 256; j++) begin
            pt_mem[j] = (j < 54) ? 8'(8'h41 + (j % 26)) : 8'h00;
            ct_mem[j] = 8'h80;
        end
        Reset = 1'b1;
        Start = 1'b0;
        PreLength = 5'd10;
        TapPtrn = 7'h60;
        LfsrInit = 7'h01;
        tick();
        tick();
        Reset = 1'b0;

        chk("rst_busy", Busy, 0);
        chk("rst_ack", Ack, 0);
        chk("rst_wren", MemWrEn, 0);
        chk("rst_outs", {MemRdAddr, MemWrAddr, MemWrData}, 0);
        repeat (5) tick();
        chk("no_launch_busy", Busy, 0);

        // Case 1: tap 0x60, init 0x01, pre 10
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd10, 7'h60, 7'h01, 400, 1'b0, edges);
        chk("c1_ack_edges", edges, 129);
        chk("c1_ack", Ack, 1);
        chk("c1_busy", Busy, 0);
        for (int i = 0; i < 7; i++)
            chk($sformatf("c1_byte%0d", 64 + i), ct_mem[64+i], hand1[i]);
        chk("c1_byte74", ct_mem[74], 8'h59);
        build_exp(10, 7'h60, 7'h01);
        cmp_exp("c1", wc0);
        for (int i = 0; i < 64; i++) case1_ct[i] = ct_mem[64+i];

        // Case 2: zero init behaves as 0x01
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd10, 7'h60, 7'h00, 400, 1'b0, edges);
        cmp_case1("c2", wc0);

        // Case 3: pre-length clamping at both ends
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd3, 7'h60, 7'h01, 400, 1'b0, edges);
        chk("c3_lo_byte74", ct_mem[74], 8'h59);
        cmp_case1("c3_lo", wc0);
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd31, 7'h60, 7'h01, 400, 1'b0, edges);
        chk("c3_hi_byte90", ct_mem[90], B90);
        build_exp(26, 7'h60, 7'h01);
        cmp_exp("c3_hi", wc0);

        // Case 4: plaintext bit 7 ignored
        for (int j = 0; j < 54; j++) pt_mem[j] = pt_mem[j] | 8'h80;
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd10, 7'h60, 7'h01, 400, 1'b0, edges);
        chk("c4_byte74", ct_mem[74], 8'h59);
        cmp_case1("c4", wc0);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
`ifdef LFSR_ENC_PARITY_EN
            if (^ct_mem[64+i] !== 1'b0) bad++;
`else
            if (ct_mem[64+i][7] !== 1'b0) bad++;
`endif
        end
        chk("c4_parity", bad, 0);
        for (int j = 0; j < 54; j++) pt_mem[j] = pt_mem[j] & 8'h7F;

        // Case 5: reset mid-run
        Start = 1'b1;
        tick();
        launch(5'd10, 7'h60, 7'h01, 40, 1'b0, edges);
        chk("c5_busy_mid", Busy, 1);
        Reset = 1'b1;
        tick();
        wc0 = wr_cnt;
        Reset = 1'b0;
        chk("c5_rst_outs", {MemWrEn, Busy, Ack}, 0);
        wen_seen = 0;
        repeat (50) begin
            tick();
            if (MemWrEn || Busy || Ack) wen_seen++;
        end
        chk("c5_idle_quiet", wen_seen, 0);
        chk("c5_no_writes", wr_cnt - wc0, 0);
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd10, 7'h60, 7'h01, 400, 1'b0, edges);
        chk("c5_ack_edges", edges, 129);
        cmp_case1("c5", wc0);

        // Case 6: Start toggling mid-run, then Ack handshake and new tap
        Start = 1'b1;
        tick();
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd10, 7'h60, 7'h01, 400, 1'b1, edges);
        chk("c6_ack_edges", edges, 129);
        cmp_case1("c6", wc0);
        Start = 1'b1;
        tick();
        chk("c6_ack_drop", Ack, 0);
        clear_ct();
        wc0 = wr_cnt;
        launch(5'd10, 7'h48, 7'h01, 400, 1'b0, edges);
        chk("c6b_ack_edges", edges, 129);
        chk("c6b_ack", Ack, 1);
        build_exp(10, 7'h48, 7'h01);
        cmp_exp("c6b", wc0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfsr_encrypt_engine.md
Name: lfsr_encrypt_engine

Overview:
Hardware encryptor for the LFSR stream cipher with parity-prefixed ciphertext; it is the transmit side of the message decrypt/depad flow.
- Reads a plaintext message from data memory and front-pads it with ASCII spaces (0x20).
- XORs each byte with a 7-bit maximal-length LFSR, then puts even parity of bits [6:0] into bit 7.
- Writes 64 ciphertext bytes into the upper data-memory window, where the decrypt program consumes them.
- Sits beside the core as a Start/Ack accelerator sharing the data-memory port.

Parameters:
NUM_BYTES, 64, ciphertext bytes produced per run.
MSG_MAX, 54, maximum plaintext bytes read; plaintext lives at addresses 0..MSG_MAX-1.
CT_BASE, 64, base address of the ciphertext window.
ADDR_W, 8, data-memory address width.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  1 = hold idle and load config; first cycle at 0 launches a run.
PreLength  in  5  number of leading space bytes; clamped to 10..26.
TapPtrn  in  7  LFSR feedback tap mask.
LfsrInit  in  7  LFSR start state; 0 is replaced by 1.
MemRdAddr  out  ADDR_W  plaintext read address.
MemRdData  in  8  read data; valid the cycle after MemRdAddr is presented.
MemWrEn  out  1  ciphertext write strobe.
MemWrAddr  out  ADDR_W  ciphertext write address.
MemWrData  out  8  ciphertext byte.
Busy  out  1  run in progress.
Ack  out  1  run complete; held until Start is reasserted.

Behaviour:
Reset values:
- All outputs 0; state IDLE; LFSR register 0x01; byte index 0.

Configuration latching:
- IDLE with Start=1: each cycle latch the clamped PreLength (<10→10, >26→26), TapPtrn, and LfsrInit (0→1).
- IDLE with Start=0 after a cycle with Start=1: go to RD with index i=0 and Busy=1.
- Start held low out of reset does not launch a run.

RD state (byte i):
- Let k = i − pre.
- If 0 ≤ k < MSG_MAX: MemRdAddr = k.
- Otherwise MemRdAddr = 0 and the byte is taken as 0x20.
- Next state: WR.

WR state (byte i):
- p = selected byte: MemRdData or 0x20.
- c[6:0] = p[6:0] ^ lfsr; c[7] = ^c[6:0]. Plaintext bit 7 is discarded.
- Outputs: MemWrEn=1, MemWrAddr = CT_BASE+i, MemWrData = c.
- LFSR update: lfsr ← {lfsr[5:0], ^(lfsr & TapPtrn)}.
- i ← i+1. If i was NUM_BYTES−1, go to DONE; otherwise go to RD.

Timing:
- Fixed 2 cycles per byte. The last write occurs 2·NUM_BYTES cycles after launch (128 at default).
- The next edge enters DONE: Ack=1, Busy=0.

DONE state:
- Start=1 → IDLE next cycle, Ack=0, and config latches that cycle.
- Start=0 → remain in DONE.

Other rules:
- Start changes during RD/WR are ignored.
- The index never wraps: exactly NUM_BYTES writes per run.
- MemWrEn is 0 in every state except WR.
- Reset mid-run: next edge returns to IDLE with all outputs 0; no further writes occur.

Optional Feature:
LFSR_ENC_PARITY_EN
- Defined: c[7] = ^c[6:0], as above.
- Undefined: c[7] = 0, giving plain 7-bit ciphertext. All other behaviour is unchanged.

Test Plan:
1. Tap 0x60, init 0x01, pre 10:
   - LFSR sequence 01,02,04,08,10,20,41.
   - Expected mem[64..70] = 21,22,24,28,30,00,E1.
   - Ack rises 129 edges after launch.
2. LfsrInit=0x00, otherwise as case 1 → output bytes identical to case 1.
3. PreLength=3, plaintext "A" at mem[0] → clamped to 10:
   - mem[64..73] are padded spaces.
   - mem[74] = 0x41 ^ lfsr[10] with correct parity.
   - PreLength=31 → mem[90] derives from mem[0].
4. Plaintext bytes with bit 7 set (0xC1) → ciphertext identical to plaintext 0x41; every output byte has even parity over [7:0].
5. Reset asserted 40 cycles into a run → MemWrEn stays 0 afterwards, Ack=0, Busy=0; a relaunch reproduces the full case-1 output.
6. Start toggled during a run → no effect. Start=1 in DONE drops Ack the next cycle; a second run with tap 0x48 completes with a fresh Ack.
